// File: rtl/md_egress_dispatcher_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_egress_dispatcher_pkg: metadata field positions and FSM state codes.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package md_egress_dispatcher_pkg;

    localparam int MD_DISCARD_BIT = 128;
    localparam int MD_DST_PORT_HI = 31;
    localparam int MD_DST_PORT_LO = 24;
    localparam int MD_NXT_TBL_HI  = 255;
    localparam int MD_NXT_TBL_LO  = 250;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/md_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_sync_fifo: first-word-fall-through synchronous FIFO with full/empty.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module md_sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE = 1;
    localparam logic [AW:0]   c_CNT_ONE = 1;
    localparam logic [AW:0]   c_CNT_MAX = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == c_CNT_MAX);
    assign empty   = (r_count == '0);
    assign rd_data = r_mem[r_rd_ptr];
    assign w_pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push at full is accepted then.
    assign w_push  = wr_en && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/md_egress_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_egress_dispatcher: pairs packets with final metadata; drops or forwards |
// | with dst_port patched into the first-beat tuser. Rev 1.0                   |
// +----------------------------------------------------------------------------+
module md_egress_dispatcher
    import md_egress_dispatcher_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int META_LEN             = 256,
    parameter int META_FIFO_DEPTH      = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [META_LEN-1:0]                 meta_in,
    input  logic                                meta_valid_in,
    output logic                                meta_full,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    output logic                                s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    output logic [31:0]                         drop_cnt,
    output logic [31:0]                         fwd_cnt,
    output logic                                meta_ovf
);

    logic [1:0]                        r_state;
    logic [7:0]                        r_dst_port;
    logic                              r_first;
    logic [31:0]                       r_drop_cnt;
    logic [31:0]                       r_fwd_cnt;
    logic                              r_meta_ovf;

    logic [META_LEN-1:0]               w_head;
    logic                              w_empty;
    logic                              w_pop;
    logic                              w_fwd;
    logic                              w_drop;
    logic                              w_s_hs;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   w_tuser_patched;
    logic                              w_unused_meta;

    md_sync_fifo #(
        .WIDTH (META_LEN),
        .DEPTH (META_FIFO_DEPTH)
    ) u_meta_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (meta_valid_in),
        .wr_data (meta_in),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (meta_full),
        .empty   (w_empty)
    );

    // Only discard and dst_port matter at egress; next_table_id and the rest are dead here.
    assign w_unused_meta = ^{w_head[META_LEN-1:MD_DISCARD_BIT+1],
                             w_head[MD_DISCARD_BIT-1:MD_DST_PORT_HI+1],
                             w_head[MD_DST_PORT_LO-1:0]};

    assign w_pop  = (r_state == ST_IDLE) && !w_empty && s_axis_tvalid;
    assign w_fwd  = (r_state == ST_FWD);
    assign w_drop = (r_state == ST_DROP);
    assign w_s_hs = s_axis_tvalid && s_axis_tready;

    always_comb begin
        w_tuser_patched = s_axis_tuser;
        if (r_first) begin
            w_tuser_patched[MD_DST_PORT_HI:MD_DST_PORT_LO] = r_dst_port;
        end
    end

    // Master side is held at zero outside FWD so every output is quiet in IDLE/DROP.
    assign s_axis_tready = w_fwd ? m_axis_tready : w_drop;
    assign m_axis_tvalid = w_fwd && s_axis_tvalid;
    assign m_axis_tdata  = w_fwd ? s_axis_tdata : '0;
    assign m_axis_tkeep  = w_fwd ? s_axis_tkeep : '0;
    assign m_axis_tlast  = w_fwd && s_axis_tlast;
    assign m_axis_tuser  = w_fwd ? w_tuser_patched : '0;

    assign drop_cnt = r_drop_cnt;
    assign fwd_cnt  = r_fwd_cnt;
    assign meta_ovf = r_meta_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_dst_port <= '0;
            r_first    <= 1'b0;
            r_drop_cnt <= '0;
            r_fwd_cnt  <= '0;
            r_meta_ovf <= 1'b0;
        end else begin
            if (meta_valid_in && meta_full && !w_pop) begin
                r_meta_ovf <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_dst_port <= w_head[MD_DST_PORT_HI:MD_DST_PORT_LO];
                        r_first    <= 1'b1;
                        r_state    <= w_head[MD_DISCARD_BIT] ? ST_DROP : ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (w_s_hs) begin
                        r_first <= 1'b0;
                        if (s_axis_tlast) begin
                            r_fwd_cnt <= r_fwd_cnt + 32'd1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_drop_cnt <= r_drop_cnt + 32'd1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_egress_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_md_egress_dispatcher: directed self-checking bench for the dispatcher.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_md_egress_dispatcher;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] meta_in;
    logic         meta_valid_in;
    logic         meta_full;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic [31:0]  drop_cnt;
    logic [31:0]  fwd_cnt;
    logic         meta_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    int mvalid_seen = 0;
    int in_acc   = 0;
    bit tready_toggle = 1'b0;

    logic [31:0]  q_data[$];
    logic [127:0] q_user[$];
    logic         q_last[$];

    always #5 clk = ~clk;

    md_egress_dispatcher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .meta_in       (meta_in),
        .meta_valid_in (meta_valid_in),
        .meta_full     (meta_full),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .drop_cnt      (drop_cnt),
        .fwd_cnt       (fwd_cnt),
        .meta_ovf      (meta_ovf)
    );

    function automatic logic [127:0] mk_user(input logic [7:0] b);
        return {96'hCAFE00001111222233334444, b, 24'hABCDEF};
    endfunction

    // One clock: inputs are already set after a negedge; observe mid-cycle, then move to the next negedge.
    task automatic cyc(output logic acc);
        m_axis_tready = tready_toggle ? cyc_n[0] : 1'b1;
        #2;
        acc = s_axis_tvalid && s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata[31:0]);
            q_user.push_back(m_axis_tuser);
            q_last.push_back(m_axis_tlast);
        end
        if (m_axis_tvalid) mvalid_seen++;
        if (acc) in_acc++;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic push_meta(input logic [7:0] port, input logic discard);
        logic acc;
        meta_in = '0;
        meta_in[255:250] = 6'h2A;
        meta_in[128] = discard;
        meta_in[31:24] = port;
        meta_valid_in = 1'b1;
        cyc(acc);
        meta_valid_in = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input logic [31:0] tag, input logic [7:0] ub, output int ncyc);
        logic acc;
        ncyc = 0;
        for (int i = 0; i < nb; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {224'd0, tag + 32'(i)};
            s_axis_tkeep  = '1;
            s_axis_tuser  = mk_user(ub);
            s_axis_tlast  = (i == nb - 1);
            acc = 1'b0;
            while (!acc && ncyc < 200) begin
                cyc(acc);
                ncyc++;
            end
            if (!acc) begin
                n_checks++;
                $display("FAIL send_pkt timeout: beat %0d of tag %0h never accepted", i, tag);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic clear_obs();
        q_data.delete(); q_user.delete(); q_last.delete();
        mvalid_seen = 0; in_acc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        #2;
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset m_tvalid: got %0b want 0", m_axis_tvalid); else n_pass++;
        n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL reset s_tready: got %0b want 0", s_axis_tready); else n_pass++;
        n_checks++; if ({fwd_cnt, drop_cnt} !== 64'd0) $display("FAIL reset counters: got %0h want 0", {fwd_cnt, drop_cnt}); else n_pass++;
        n_checks++; if ({meta_full, meta_ovf} !== 2'b00) $display("FAIL reset flags: got %0b want 00", {meta_full, meta_ovf}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        int nc;
        clear_obs();
        push_meta(8'h04, 1'b0);
        send_pkt(3, 32'h100, 8'h01, nc);
        n_checks++; if (nc !== 4) $display("FAIL fwd cycles: got %0d want 4", nc); else n_pass++;
        n_checks++; if (q_data.size() !== 3) $display("FAIL fwd beat count: got %0d want 3", q_data.size()); else n_pass++;
        if (q_data.size() == 3) begin
            n_checks++; if (q_user[0] !== mk_user(8'h04)) $display("FAIL fwd beat0 tuser: got %h want %h", q_user[0], mk_user(8'h04)); else n_pass++;
            n_checks++; if (q_user[1] !== mk_user(8'h01) || q_user[2] !== mk_user(8'h01)) $display("FAIL fwd later tuser: got %h want %h", q_user[2], mk_user(8'h01)); else n_pass++;
            n_checks++; if ({q_data[0], q_data[1], q_data[2]} !== {32'h100, 32'h101, 32'h102}) $display("FAIL fwd data order: got %h want 000001000000010100000102", {q_data[0], q_data[1], q_data[2]}); else n_pass++;
            n_checks++; if ({q_last[0], q_last[1], q_last[2]} !== 3'b001) $display("FAIL fwd tlast: got %b want 001", {q_last[0], q_last[1], q_last[2]}); else n_pass++;
        end
        n_checks++; if (fwd_cnt !== 32'd1) $display("FAIL fwd_cnt: got %0d want 1", fwd_cnt); else n_pass++;
    endtask

    task automatic test_drop();
        int nc;
        clear_obs();
        push_meta(8'h05, 1'b1);
        send_pkt(4, 32'h200, 8'h02, nc);
        n_checks++; if (nc !== 5) $display("FAIL drop cycles: got %0d want 5", nc); else n_pass++;
        n_checks++; if (in_acc !== 4) $display("FAIL drop accepted beats: got %0d want 4", in_acc); else n_pass++;
        n_checks++; if (mvalid_seen !== 0) $display("FAIL drop m_tvalid cycles: got %0d want 0", mvalid_seen); else n_pass++;
        n_checks++; if (drop_cnt !== 32'd1) $display("FAIL drop_cnt: got %0d want 1", drop_cnt); else n_pass++;
    endtask

    task automatic test_ordering();
        int nc;
        clear_obs();
        push_meta(8'h10, 1'b0);
        push_meta(8'h20, 1'b1);
        push_meta(8'h40, 1'b0);
        send_pkt(1, 32'h301, 8'h00, nc);
        send_pkt(1, 32'h302, 8'h00, nc);
        send_pkt(1, 32'h303, 8'h00, nc);
        n_checks++; if (q_data.size() !== 2) $display("FAIL order out count: got %0d want 2", q_data.size()); else n_pass++;
        if (q_data.size() == 2) begin
            n_checks++; if (q_data[0] !== 32'h301 || q_user[0] !== mk_user(8'h10)) $display("FAIL order pkt1: got %h/%h want 301/%h", q_data[0], q_user[0], mk_user(8'h10)); else n_pass++;
            n_checks++; if (q_data[1] !== 32'h303 || q_user[1] !== mk_user(8'h40)) $display("FAIL order pkt3: got %h/%h want 303/%h", q_data[1], q_user[1], mk_user(8'h40)); else n_pass++;
        end
        // Counters are cumulative: one packet of each kind came before this test.
        n_checks++; if ({fwd_cnt, drop_cnt} !== {32'd3, 32'd2}) $display("FAIL order counters: got fwd %0d drop %0d want 3/2", fwd_cnt, drop_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        int nc;
        clear_obs();
        tready_toggle = 1'b1;
        push_meta(8'h22, 1'b0);
        send_pkt(4, 32'h400, 8'h03, nc);
        tready_toggle = 1'b0;
        n_checks++; if (q_data.size() !== 4) $display("FAIL bp beat count: got %0d want 4", q_data.size()); else n_pass++;
        if (q_data.size() == 4) begin
            n_checks++; if ({q_data[0], q_data[1], q_data[2], q_data[3]} !== {32'h400, 32'h401, 32'h402, 32'h403}) $display("FAIL bp data order: got %h", {q_data[0], q_data[1], q_data[2], q_data[3]}); else n_pass++;
            n_checks++; if (q_user[0] !== mk_user(8'h22)) $display("FAIL bp beat0 tuser: got %h want %h", q_user[0], mk_user(8'h22)); else n_pass++;
            n_checks++; if (q_user[1] !== mk_user(8'h03) || q_user[3] !== mk_user(8'h03)) $display("FAIL bp later tuser: got %h want %h", q_user[1], mk_user(8'h03)); else n_pass++;
        end
        n_checks++; if (fwd_cnt !== 32'd4) $display("FAIL bp fwd_cnt: got %0d want 4", fwd_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        logic acc;
        int stall_acc = 0;
        int n = 0;
        clear_obs();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {224'd0, 32'h480};
        s_axis_tkeep  = '1;
        s_axis_tuser  = mk_user(8'h07);
        s_axis_tlast  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(acc);
            if (acc) stall_acc++;
        end
        n_checks++; if (stall_acc !== 0) $display("FAIL stall accepted with empty fifo: got %0d want 0", stall_acc); else n_pass++;
        meta_in = '0;
        meta_in[31:24] = 8'h66;
        meta_valid_in = 1'b1;
        cyc(acc);
        meta_valid_in = 1'b0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            cyc(acc);
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        n_checks++; if (!acc) $display("FAIL stall release: got not accepted want accepted"); else n_pass++;
        n_checks++; if (q_user.size() !== 1 || q_user[0] !== mk_user(8'h66)) $display("FAIL stall tuser: got %0d beats want 1 with port 66", q_user.size()); else n_pass++;
    endtask

    task automatic test_full();
        logic acc;
        int n = 0;
        int nc;
        logic [7:0] want;
        clear_obs();
        for (int i = 0; i < 15; i++) push_meta(8'h80 + 8'(i), 1'b0);
        n_checks++; if (meta_full !== 1'b0) $display("FAIL full at 15: got %0b want 0", meta_full); else n_pass++;
        push_meta(8'h8F, 1'b0);
        n_checks++; if ({meta_full, meta_ovf} !== 2'b10) $display("FAIL full at 16: got full,ovf=%b want 10", {meta_full, meta_ovf}); else n_pass++;
        push_meta(8'h90, 1'b0);
        n_checks++; if ({meta_full, meta_ovf} !== 2'b11) $display("FAIL overflow: got full,ovf=%b want 11", {meta_full, meta_ovf}); else n_pass++;
        // Push and pop together while full.
        meta_in = '0;
        meta_in[31:24] = 8'hEE;
        meta_valid_in = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {224'd0, 32'h500};
        s_axis_tkeep  = '1;
        s_axis_tuser  = mk_user(8'h00);
        s_axis_tlast  = 1'b1;
        cyc(acc);
        meta_valid_in = 1'b0;
        n_checks++; if (meta_full !== 1'b1) $display("FAIL push+pop at full: got full=%0b want 1", meta_full); else n_pass++;
        acc = 1'b0;
        while (!acc && n < 10) begin
            cyc(acc);
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 1; i <= 16; i++) send_pkt(1, 32'h500 + 32'(i), 8'h00, nc);
        n_checks++; if (q_user.size() !== 17) $display("FAIL drain count: got %0d want 17", q_user.size()); else n_pass++;
        for (int i = 0; i < 17 && i < q_user.size(); i++) begin
            want = (i == 16) ? 8'hEE : 8'h80 + 8'(i);
            n_checks++; if (q_user[i] !== mk_user(want)) $display("FAIL drain entry %0d: got %h want port %h", i, q_user[i][31:24], want); else n_pass++;
        end
        n_checks++; if ({meta_full, meta_ovf} !== 2'b01) $display("FAIL after drain: got full,ovf=%b want 01", {meta_full, meta_ovf}); else n_pass++;
        n_checks++; if (fwd_cnt !== 32'd22) $display("FAIL full fwd_cnt: got %0d want 22", fwd_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        logic acc;
        int stall_acc = 0;
        int nc;
        clear_obs();
        push_meta(8'h99, 1'b0);
        push_meta(8'h33, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tkeep  = '1;
        s_axis_tuser  = mk_user(8'h0A);
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = {224'd0, 32'h600};
        cyc(acc);
        cyc(acc);
        s_axis_tdata  = {224'd0, 32'h601};
        cyc(acc);
        s_axis_tdata  = {224'd0, 32'h602};
        rst_n = 1'b0;
        cyc(acc);
        #2;
        n_checks++; if ({m_axis_tvalid, s_axis_tready, m_axis_tlast} !== 3'b000) $display("FAIL rst mid handshake: got %b want 000", {m_axis_tvalid, s_axis_tready, m_axis_tlast}); else n_pass++;
        n_checks++; if (m_axis_tdata !== '0 || m_axis_tuser !== '0 || m_axis_tkeep !== '0) $display("FAIL rst mid data: got %h want 0", m_axis_tdata[31:0]); else n_pass++;
        n_checks++; if ({fwd_cnt, drop_cnt, 6'd0, meta_full, meta_ovf} !== 72'd0) $display("FAIL rst mid state: got fwd %0d drop %0d full %0b ovf %0b want all 0", fwd_cnt, drop_cnt, meta_full, meta_ovf); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        s_axis_tdata  = {224'd0, 32'h700};
        s_axis_tuser  = mk_user(8'h0B);
        s_axis_tlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(acc);
            if (acc) stall_acc++;
        end
        n_checks++; if (stall_acc !== 0) $display("FAIL rst fifo not empty: got %0d accepts want 0", stall_acc); else n_pass++;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear_obs();
        push_meta(8'h55, 1'b0);
        send_pkt(2, 32'h700, 8'h0B, nc);
        n_checks++; if (q_user.size() !== 2 || q_user[0] !== mk_user(8'h55) || q_data[1] !== 32'h701) $display("FAIL post-reset fwd: got %0d beats want 2 with port 55", q_user.size()); else n_pass++;
        n_checks++; if (fwd_cnt !== 32'd1) $display("FAIL post-reset fwd_cnt: got %0d want 1", fwd_cnt); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        meta_in = '0;
        meta_valid_in = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tuser = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        test_reset();
        test_forward();
        test_drop();
        test_ordering();
        test_backpressure();
        test_stall();
        test_full();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
